// File: rtl/vending_machine_mp.sv
// Multi-product vending controller: coin credit, N_PROD slots at one PRICE, greedy serial change, refund, restock.
// Latency: coin/sel/cancel sampled at edge k act in cycle k+1; change coins then stream one per cycle.
// Backpressure: none upstream; coins offered while busy or over the credit ceiling are bounced via coin_reject.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   nickel, dime, quarter    one-cycle coin pulses (more than one high = illegal coin)
//   sel [N_PROD]             one-hot product request pulse
//   cancel                   refund request pulse
//   restock, restock_id      add one unit to slot restock_id (saturating)
//   credit                   current credit in cents
//   vend [N_PROD]            one-cycle dispense pulse
//   change_quarter/dime/nickel  one-cycle change-coin pulses, at most one per cycle
//   coin_reject              previous-edge coin was returned
//   sold_out [N_PROD]        slot stock is zero
//   busy                     machine is in VEND or CHANGE
module vending_machine_mp #(
   parameter int PRICE      = 20,
   parameter int MAX_CREDIT = 60,
   parameter int N_PROD     = 2,
   parameter int STOCK_MAX  = 7,
   localparam int CREDIT_W  = $clog2(MAX_CREDIT + 1),
   localparam int ID_W      = (N_PROD > 1) ? $clog2(N_PROD) : 1,
   localparam int STOCK_W   = $clog2(STOCK_MAX + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                nickel,
   input  logic                dime,
   input  logic                quarter,
   input  logic [N_PROD-1:0]   sel,
   input  logic                cancel,
   input  logic                restock,
   input  logic [ID_W-1:0]     restock_id,
   output logic [CREDIT_W-1:0] credit,
   output logic [N_PROD-1:0]   vend,
   output logic                change_quarter,
   output logic                change_dime,
   output logic                change_nickel,
   output logic                coin_reject,
   output logic [N_PROD-1:0]   sold_out,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [N_PROD-1:0]   vend_q, vend_d;
   logic                reject_q, reject_d;
   logic [STOCK_W-1:0]  stock_q [N_PROD];
   logic [STOCK_W-1:0]  stock_d [N_PROD];

   logic [1:0]          coin_cnt;
   logic                coin_any;
   logic                coin_ok;
   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W:0]   credit_sum;
   logic                sel_ok;
   logic [N_PROD-1:0]   take;
   logic [N_PROD-1:0]   restock_hit;
   logic [CREDIT_W-1:0] chg_val;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         credit_q <= '0;
         vend_q   <= '0;
         reject_q <= 1'b0;
         for (int i = 0; i < N_PROD; i++) stock_q[i] <= STOCK_W'(STOCK_MAX);
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         vend_q   <= vend_d;
         reject_q <= reject_d;
         stock_q  <= stock_d;
      end
   end

   always_comb begin
      coin_cnt   = {1'b0, nickel} + {1'b0, dime} + {1'b0, quarter};
      coin_any   = nickel | dime | quarter;
      coin_ok    = (coin_cnt == 2'd1);
      coin_val   = quarter ? CREDIT_W'(25) : (dime ? CREDIT_W'(10) : CREDIT_W'(5));
      // One extra bit so the ceiling check sees the true sum before it is committed.
      credit_sum = {1'b0, credit_q} + {1'b0, coin_val};

      sel_ok = 1'b0;
      for (int i = 0; i < N_PROD; i++) begin
         if (sel[i] && (stock_q[i] != '0)) sel_ok = 1'b1;
      end
      sel_ok = sel_ok && $onehot(sel) && (credit_q >= CREDIT_W'(PRICE));

      // Greedy change coin; credit is always a multiple of 5 and non-zero in CHANGE.
      if (credit_q >= CREDIT_W'(25))      chg_val = CREDIT_W'(25);
      else if (credit_q >= CREDIT_W'(10)) chg_val = CREDIT_W'(10);
      else                                chg_val = CREDIT_W'(5);

      state_d  = state_q;
      credit_d = credit_q;
      vend_d   = '0;
      reject_d = 1'b0;
      take     = '0;

      case (state_q)
         IDLE: begin
            if (cancel && (credit_q != '0)) begin
               state_d  = CHANGE;
               reject_d = coin_any;
            end else if (sel_ok) begin
               credit_d = credit_q - CREDIT_W'(PRICE);
               take     = sel;
               vend_d   = sel;
               state_d  = VEND;
               reject_d = coin_any;
            end else if (coin_any) begin
               if (coin_ok && (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT)))
                  credit_d = credit_sum[CREDIT_W-1:0];
               else
                  reject_d = 1'b1;
            end
         end
         VEND: begin
            reject_d = coin_any;
            state_d  = (credit_q != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            reject_d = coin_any;
            credit_d = credit_q - chg_val;
            if (credit_d == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A restock landing on the slot being vended cancels the decrement.
      stock_d = stock_q;
      for (int i = 0; i < N_PROD; i++) begin
         restock_hit[i] = restock && (restock_id == ID_W'(i));
         if (take[i] && !restock_hit[i])
            stock_d[i] = stock_q[i] - 1'b1;
         else if (restock_hit[i] && !take[i] && (stock_q[i] != STOCK_W'(STOCK_MAX)))
            stock_d[i] = stock_q[i] + 1'b1;
      end
   end

   // Outputs decode registered state only.
   always_comb begin
      credit         = credit_q;
      vend           = vend_q;
      coin_reject    = reject_q;
      busy           = (state_q != IDLE);
      change_quarter = 1'b0;
      change_dime    = 1'b0;
      change_nickel  = 1'b0;
      if (state_q == CHANGE) begin
         change_quarter = (chg_val == CREDIT_W'(25));
         change_dime    = (chg_val == CREDIT_W'(10));
         change_nickel  = (chg_val == CREDIT_W'(5));
      end
      for (int i = 0; i < N_PROD; i++) sold_out[i] = (stock_q[i] == '0);
   end

endmodule

// File: tb/tb_vending_machine_mp.sv
// Bench for vending_machine_mp at default parameters (PRICE 20, MAX_CREDIT 60, 2 slots, stock 7).
// Vectors hold one cycle of inputs plus the outputs expected in the following cycle.
// Expected outputs go onto a queue when a vector is driven and are popped when the DUT responds.
module tb_vending_machine_mp;

   typedef struct packed {
      logic       n;
      logic       d;
      logic       q;
      logic [1:0] sel;
      logic       cancel;
      logic       restock;
      logic       rid;
   } in_t;

   typedef struct packed {
      logic [5:0] credit;
      logic [1:0] vend;
      logic       cq;
      logic       cd;
      logic       cn;
      logic       rej;
      logic [1:0] so;
      logic       busy;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       nickel, dime, quarter;
   logic [1:0] sel;
   logic       cancel;
   logic       restock;
   logic       restock_id;
   logic [5:0] credit;
   logic [1:0] vend;
   logic       change_quarter, change_dime, change_nickel;
   logic       coin_reject;
   logic [1:0] sold_out;
   logic       busy;

   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t tbl[$];
   out_t exp_q[$];

   vending_machine_mp #(
      .PRICE(20), .MAX_CREDIT(60), .N_PROD(2), .STOCK_MAX(7)
   ) dut (
      .clk(clk), .rst(rst),
      .nickel(nickel), .dime(dime), .quarter(quarter),
      .sel(sel), .cancel(cancel), .restock(restock), .restock_id(restock_id),
      .credit(credit), .vend(vend),
      .change_quarter(change_quarter), .change_dime(change_dime), .change_nickel(change_nickel),
      .coin_reject(coin_reject), .sold_out(sold_out), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic in_t mk_in(input logic n, input logic d, input logic q,
                                 input logic [1:0] s, input logic c,
                                 input logic r, input logic id);
      in_t v;
      v = {n, d, q, s, c, r, id};
      return v;
   endfunction

   function automatic out_t mk_out(input int cr, input logic [1:0] v, input logic cq,
                                   input logic cd, input logic cn, input logic rej,
                                   input logic [1:0] so, input logic b);
      out_t o;
      o = {6'(cr), v, cq, cd, cn, rej, so, b};
      return o;
   endfunction

   function automatic in_t nop();
      return mk_in(0, 0, 0, 2'b00, 0, 0, 0);
   endfunction

   function automatic out_t idle_out(input int cr, input logic [1:0] so);
      return mk_out(cr, 2'b00, 0, 0, 0, 0, so, 0);
   endfunction

   task automatic add(input in_t i, input out_t o);
      vec_t v;
      v.i = i;
      v.o = o;
      tbl.push_back(v);
   endtask

   // Seven exact-price purchases from one slot; the last one empties it.
   task automatic add_sellout(input logic [1:0] m);
      for (int k = 1; k <= 7; k++) begin
         add(mk_in(0, 1, 0, 2'b00, 0, 0, 0), idle_out(10, 2'b00));
         add(mk_in(0, 1, 0, 2'b00, 0, 0, 0), idle_out(20, 2'b00));
         // On the third purchase a nickel rides along with the sel and must bounce.
         add(mk_in(k == 3, 0, 0, m, 0, 0, 0),
             mk_out(0, m, 0, 0, 0, k == 3, (k == 7) ? m : 2'b00, 1));
         add(nop(), idle_out(0, (k == 7) ? m : 2'b00));
      end
   endtask

   task automatic check(input string name, input out_t e);
      out_t a;
      a = {credit, vend, change_quarter, change_dime, change_nickel, coin_reject, sold_out, busy};
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got credit=%0d vend=%b q/d/n=%b%b%b rej=%b sold_out=%b busy=%b ; expected credit=%0d vend=%b q/d/n=%b%b%b rej=%b sold_out=%b busy=%b",
                  name, a.credit, a.vend, a.cq, a.cd, a.cn, a.rej, a.so, a.busy,
                  e.credit, e.vend, e.cq, e.cd, e.cn, e.rej, e.so, e.busy);
      end
   endtask

   task automatic step(input string name, input in_t v, input out_t e);
      out_t exp_v;
      {nickel, dime, quarter, sel, cancel, restock, restock_id} = v;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      {nickel, dime, quarter, sel, cancel, restock, restock_id} = '0;
      exp_v = exp_q.pop_front();
      check(name, exp_v);
   endtask

   initial begin
      rst = 1'b1;
      {nickel, dime, quarter, sel, cancel, restock, restock_id} = '0;

      // Idle hold after reset.
      for (int k = 0; k < 5; k++) add(nop(), idle_out(0, 2'b00));

      // 10+5+25 = 40, buy slot 0, two dimes back.
      add(mk_in(0, 1, 0, 2'b00, 0, 0, 0), idle_out(10, 2'b00));
      add(mk_in(1, 0, 0, 2'b00, 0, 0, 0), idle_out(15, 2'b00));
      add(mk_in(0, 0, 1, 2'b00, 0, 0, 0), idle_out(40, 2'b00));
      add(mk_in(0, 0, 0, 2'b01, 0, 0, 0), mk_out(20, 2'b01, 0, 0, 0, 0, 2'b00, 1));
      add(nop(), mk_out(20, 2'b00, 0, 1, 0, 0, 2'b00, 1));
      add(nop(), mk_out(10, 2'b00, 0, 1, 0, 0, 2'b00, 1));
      add(nop(), idle_out(0, 2'b00));

      // Credit ceiling.
      add(mk_in(0, 0, 1, 2'b00, 0, 0, 0), idle_out(25, 2'b00));
      add(mk_in(0, 0, 1, 2'b00, 0, 0, 0), idle_out(50, 2'b00));
      add(mk_in(0, 0, 1, 2'b00, 0, 0, 0), mk_out(50, 2'b00, 0, 0, 0, 1, 2'b00, 0));
      add(mk_in(0, 1, 0, 2'b00, 0, 0, 0), idle_out(60, 2'b00));
      add(mk_in(1, 0, 0, 2'b00, 0, 0, 0), mk_out(60, 2'b00, 0, 0, 0, 1, 2'b00, 0));
      // Refund 60 = 25 + 25 + 10.
      add(mk_in(0, 0, 0, 2'b00, 1, 0, 0), mk_out(60, 2'b00, 1, 0, 0, 0, 2'b00, 1));
      add(nop(), mk_out(35, 2'b00, 1, 0, 0, 0, 2'b00, 1));
      add(nop(), mk_out(10, 2'b00, 0, 1, 0, 0, 2'b00, 1));
      add(nop(), idle_out(0, 2'b00));

      // Refund 35 with a coin offered mid-change.
      add(mk_in(0, 0, 1, 2'b00, 0, 0, 0), idle_out(25, 2'b00));
      add(mk_in(0, 1, 0, 2'b00, 0, 0, 0), idle_out(35, 2'b00));
      add(mk_in(0, 0, 0, 2'b00, 1, 0, 0), mk_out(35, 2'b00, 1, 0, 0, 0, 2'b00, 1));
      add(mk_in(1, 0, 0, 2'b00, 0, 0, 0), mk_out(10, 2'b00, 0, 1, 0, 1, 2'b00, 1));
      add(nop(), idle_out(0, 2'b00));

      // Illegal coin, cancel with coin, cancel at zero, sel without credit.
      add(mk_in(1, 0, 0, 2'b00, 0, 0, 0), idle_out(5, 2'b00));
      add(mk_in(1, 1, 0, 2'b00, 0, 0, 0), mk_out(5, 2'b00, 0, 0, 0, 1, 2'b00, 0));
      add(mk_in(0, 1, 0, 2'b00, 1, 0, 0), mk_out(5, 2'b00, 0, 0, 1, 1, 2'b00, 1));
      add(nop(), idle_out(0, 2'b00));
      add(mk_in(0, 0, 0, 2'b00, 1, 0, 0), idle_out(0, 2'b00));
      add(mk_in(0, 0, 0, 2'b01, 0, 0, 0), idle_out(0, 2'b00));

      // Empty slot 1 at exact price.
      add_sellout(2'b10);
      add(mk_in(0, 1, 0, 2'b00, 0, 0, 0), idle_out(10, 2'b10));
      add(mk_in(0, 1, 0, 2'b00, 0, 0, 0), idle_out(20, 2'b10));
      add(mk_in(0, 0, 0, 2'b10, 0, 0, 0), idle_out(20, 2'b10));
      add(mk_in(1, 0, 0, 2'b10, 0, 0, 0), idle_out(25, 2'b10));
      add(mk_in(0, 0, 0, 2'b11, 0, 0, 0), idle_out(25, 2'b10));
      add(mk_in(0, 0, 0, 2'b00, 0, 1, 1), idle_out(25, 2'b00));
      add(mk_in(0, 0, 0, 2'b10, 0, 0, 0), mk_out(5, 2'b10, 0, 0, 0, 0, 2'b10, 1));
      add(nop(), mk_out(5, 2'b00, 0, 0, 1, 0, 2'b10, 1));
      add(nop(), idle_out(0, 2'b10));
      add(mk_in(0, 0, 0, 2'b00, 0, 1, 1), idle_out(0, 2'b00));

      // Slot 0: refill to 7, saturate, vend with simultaneous restock, then 7 sales empty it.
      add(mk_in(0, 0, 0, 2'b00, 0, 1, 0), idle_out(0, 2'b00));
      add(mk_in(0, 0, 0, 2'b00, 0, 1, 0), idle_out(0, 2'b00));
      add(mk_in(0, 0, 1, 2'b00, 0, 0, 0), idle_out(25, 2'b00));
      add(mk_in(0, 0, 1, 2'b00, 0, 0, 0), idle_out(50, 2'b00));
      add(mk_in(0, 0, 0, 2'b01, 0, 1, 0), mk_out(30, 2'b01, 0, 0, 0, 0, 2'b00, 1));
      add(nop(), mk_out(30, 2'b00, 1, 0, 0, 0, 2'b00, 1));
      add(nop(), mk_out(5, 2'b00, 0, 0, 1, 0, 2'b00, 1));
      add(nop(), idle_out(0, 2'b00));
      add_sellout(2'b01);
      add(mk_in(0, 0, 0, 2'b00, 0, 1, 0), idle_out(0, 2'b00));

      @(negedge clk);
      check("reset_state", idle_out(0, 2'b00));
      rst = 1'b0;

      for (int k = 0; k < tbl.size(); k++)
         step($sformatf("vec%0d", k), tbl[k].i, tbl[k].o);

      // Reset asserted during the second change coin of a 35 refund.
      step("mid_q", mk_in(0, 0, 1, 2'b00, 0, 0, 0), idle_out(25, 2'b00));
      step("mid_d", mk_in(0, 1, 0, 2'b00, 0, 0, 0), idle_out(35, 2'b00));
      step("mid_cancel", mk_in(0, 0, 0, 2'b00, 1, 0, 0), mk_out(35, 2'b00, 1, 0, 0, 0, 2'b00, 1));
      step("mid_coin2", nop(), mk_out(10, 2'b00, 0, 1, 0, 0, 2'b00, 1));
      #1;
      rst = 1'b1;
      #1;
      check("async_reset", idle_out(0, 2'b00));
      @(negedge clk);
      rst = 1'b0;
      step("after_reset", nop(), idle_out(0, 2'b00));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
